// File: rtl/jk_ff_checker.sv
// Golden-model checker for a JK flip-flop stage: predicts q each clock, flags
// mismatches and complement violations, counts toggles/errors, detects stuck q.
module jk_ff_checker #(
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned STUCK_LIM = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             j,
   input  logic             k,
   input  logic             q,
   input  logic             qb,
   output logic             pred_q,
   output logic             mismatch,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] tog_cnt,
   output logic             stuck,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SYNC  = 2'b01,
      CHECK = 2'b10,
      ERROR = 2'b11
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] STUCK_THR = CNT_W'(STUCK_LIM - 1);

   function automatic logic jk_next(input logic p, input logic jj, input logic kk);
      return (jj & ~p) | (~kk & p);
   endfunction

   state_e           state_q,    state_d;
   logic             pred_q_q,   pred_q_d;
   logic             mismatch_q, mismatch_d;
   logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;
   logic [CNT_W-1:0] tog_cnt_q,  tog_cnt_d;
   logic             stuck_q,    stuck_d;
   logic             q_prev_q,   q_prev_d;
   logic [CNT_W-1:0] run_q,      run_d;
   logic             err;
   logic             q_chg;

   always_comb begin
      state_d    = state_q;
      pred_q_d   = pred_q_q;
      mismatch_d = mismatch_q;
      err_cnt_d  = err_cnt_q;
      tog_cnt_d  = tog_cnt_q;
      stuck_d    = stuck_q;
      q_prev_d   = q_prev_q;
      run_d      = run_q;

      // A q fault and a qb fault in the same cycle are a single error
      err   = (q != pred_q_q) || (qb == q);
      q_chg = (q != q_prev_q);

      unique case (state_q)
         IDLE: begin
            if (en) state_d = SYNC;
         end
         SYNC: begin
            mismatch_d = 1'b0;
            if (!en) begin
               state_d = IDLE;
            end else begin
               pred_q_d = jk_next(q, j, k);
               q_prev_d = q;
               state_d  = CHECK;
            end
         end
         CHECK: begin
            if (!en) begin
               state_d    = IDLE;
               mismatch_d = 1'b0;
            end else begin
               mismatch_d = err;
               // Resync on error so a single fault is counted once
               pred_q_d   = err ? jk_next(q, j, k) : jk_next(pred_q_q, j, k);
               if (err && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + CNT_W'(1);
               if (err && (err_cnt_d == CNT_MAX)) state_d = ERROR;
               q_prev_d = q;
               if (q_chg) begin
                  tog_cnt_d = tog_cnt_q + CNT_W'(1);
                  run_d     = '0;
                  stuck_d   = 1'b0;
               end else begin
                  if (run_q != CNT_MAX) run_d = run_q + CNT_W'(1);
                  stuck_d = (run_q >= STUCK_THR);
               end
            end
         end
         ERROR: begin
            mismatch_d = 1'b0;
            if (!en) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pred_q_q   <= 1'b0;
         mismatch_q <= 1'b0;
         err_cnt_q  <= '0;
         tog_cnt_q  <= '0;
         stuck_q    <= 1'b0;
         q_prev_q   <= 1'b0;
         run_q      <= '0;
      end else begin
         state_q    <= state_d;
         pred_q_q   <= pred_q_d;
         mismatch_q <= mismatch_d;
         err_cnt_q  <= err_cnt_d;
         tog_cnt_q  <= tog_cnt_d;
         stuck_q    <= stuck_d;
         q_prev_q   <= q_prev_d;
         run_q      <= run_d;
      end
   end

   assign pred_q   = pred_q_q;
   assign mismatch = mismatch_q;
   assign err_cnt  = err_cnt_q;
   assign tog_cnt  = tog_cnt_q;
   assign stuck    = stuck_q;
   assign state    = state_q;

endmodule

// File: doc/jk_ff_checker.md
Name: jk_ff_checker

Overview:
- Cycle-accurate golden-model checker that sits directly downstream of the JK flip-flop stage built on the SR flip-flop.
- Consumes the stage's j, k drive and its q/qb outputs, predicts q each clock, and flags mismatches or complement violations.
- Counts toggles and errors, and detects a stuck output.
- Used in benches and as an on-chip monitor.

Parameters:
- CNT_W, 8, width of err_cnt and tog_cnt.
- STUCK_LIM, 16, consecutive checked cycles with q unchanged before stuck asserts (2..2^CNT_W-1).

Ports:
- clk  input  1  rising-edge clock, same clock as the monitored flip-flop.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  checker enable.
- j  input  1  J drive presented to the monitored flip-flop.
- k  input  1  K drive presented to the monitored flip-flop.
- q  input  1  monitored flip-flop output.
- qb  input  1  monitored flip-flop complement output.
- pred_q  output  1  predicted q for the current cycle.
- mismatch  output  1  registered one-cycle error pulse.
- err_cnt  output  CNT_W  saturating error count.
- tog_cnt  output  CNT_W  wrapping count of q transitions.
- stuck  output  1  q unchanged for STUCK_LIM checked cycles.
- state  output  2  FSM state: IDLE=00, SYNC=01, CHECK=10, ERROR=11.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; pred_q=0, mismatch=0, err_cnt=0, tog_cnt=0, stuck=0. Internal q_prev=0, run counter=0.
- JK next function: jk(p, j, k) gives p for 00, 0 for 01, 1 for 10, ~p for 11.
- IDLE: outputs hold, no checking. en=1 at an edge moves to SYNC.
- SYNC (exactly one cycle):
  - pred_q <= jk(q, j, k); q_prev <= q.
  - No compare, no counting. Next state CHECK.
- CHECK, at each rising edge:
  - err = (q != pred_q) OR (qb != ~q).
  - mismatch <= err.
  - If err: err_cnt <= err_cnt+1, saturating at 2^CNT_W-1.
  - pred_q <= jk(q, j, k) when err=1 (resync to the observed value, so one fault counts once); otherwise pred_q <= jk(pred_q, j, k).
  - If q != q_prev: tog_cnt <= tog_cnt+1, wrapping at 2^CNT_W. q_prev <= q.
  - Run counter: cleared when q changes, else increments (saturating). stuck <= (run counter reaches STUCK_LIM-1 with q unchanged). stuck clears on the first cycle q changes.
  - If err drives err_cnt to all-ones on this edge, next state is ERROR.
- ERROR:
  - Sticky; checking stops; mismatch <= 0.
  - err_cnt, tog_cnt, stuck and pred_q hold.
  - Exit only via reset or en=0.
- en=0 at an edge, from any non-IDLE state: state <= IDLE, mismatch <= 0, counters and stuck hold.
  - Re-enabling re-enters SYNC, which re-seeds the prediction; no false error after a pause.
- Simultaneous events:
  - en=0 has priority over the CHECK compare on the same edge.
  - reset overrides everything, asynchronously, and may assert mid-CHECK.
  - A qb violation and a q mismatch in the same cycle count as one error.
- Latency: a fault visible on q in cycle n produces mismatch=1 in cycle n+1 and the err_cnt increment on that same edge.
- Reset deassertion is synchronised externally. The block only requires that reset release is not on a rising clk edge.

Test Plan:
1. Reset mid-operation: assert reset during CHECK with err_cnt=3, tog_cnt=9 -> all outputs 0 immediately (before the next clk edge), state=00.
2. Correct flip-flop, en=1, j=k=1 for 10 cycles -> state goes 00->01->10, mismatch never 1, err_cnt=0, tog_cnt=10 (±1 for the SYNC cycle, per the defined SYNC rule), pred_q tracks q.
3. Fault injection, j=1 k=0 with q forced 0 for one cycle -> exactly one mismatch pulse, err_cnt=1, next cycle pred_q resynced, no further errors.
4. qb forced equal to q for 2 cycles with correct q -> two mismatch pulses, err_cnt=2; a simultaneous q fault on one of those cycles still counts once.
5. CNT_W=3, inject 7 faults -> err_cnt=7, state=11, mismatch held 0 afterwards; en=0 returns state to 00, and en=1 re-syncs with err_cnt still 7.
6. j=k=0 for STUCK_LIM=4 checked cycles -> stuck=1 on the 4th edge; then j=k=1 -> stuck=0 on the next toggle, tog_cnt increments.
